// File: rtl/bus_demux3_pkg.sv
// Shared types and defaults for the three-target request demultiplexer.
// Holds the FSM state encoding, target count and default address map.
// Pure declarations; no logic of its own.
package bus_demux3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  localparam int NUM_TARGETS = 3;

  // Target 0: data RAM (4 KiB), target 1: UART, target 2: timer.
  localparam logic [31:0] DEFAULT_BASE0 = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_MASK0 = 32'hFFFF_F000;
  localparam logic [31:0] DEFAULT_BASE1 = 32'h1000_0000;
  localparam logic [31:0] DEFAULT_MASK1 = 32'hFFFF_FF00;
  localparam logic [31:0] DEFAULT_BASE2 = 32'h1000_0100;
  localparam logic [31:0] DEFAULT_MASK2 = 32'hFFFF_FF00;

  localparam int DEFAULT_TIMEOUT = 16;

  // A target matches when the masked address equals its base.
  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/bus_demux3_if.sv
// Bundle of the initiator request/response channel and the three target channels.
// No latency: wires only.
// Backpressure is carried by req_ready and the per-target tN_ready lines.
interface bus_demux3_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        t0_valid, t0_ready, t0_we, t0_rvalid;
  logic [31:0] t0_addr, t0_wdata, t0_rdata;
  logic [3:0]  t0_be;

  logic        t1_valid, t1_ready, t1_we, t1_rvalid;
  logic [31:0] t1_addr, t1_wdata, t1_rdata;
  logic [3:0]  t1_be;

  logic        t2_valid, t2_ready, t2_we, t2_rvalid;
  logic [31:0] t2_addr, t2_wdata, t2_rdata;
  logic [3:0]  t2_be;

  // Initiator plus target models (the environment around the demux).
  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  t0_valid, t0_addr, t0_wdata, t0_we, t0_be,
    output t0_ready, t0_rvalid, t0_rdata,
    input  t1_valid, t1_addr, t1_wdata, t1_we, t1_be,
    output t1_ready, t1_rvalid, t1_rdata,
    input  t2_valid, t2_addr, t2_wdata, t2_we, t2_be,
    output t2_ready, t2_rvalid, t2_rdata
  );

  // The demux itself.
  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output t0_valid, t0_addr, t0_wdata, t0_we, t0_be,
    input  t0_ready, t0_rvalid, t0_rdata,
    output t1_valid, t1_addr, t1_wdata, t1_we, t1_be,
    input  t1_ready, t1_rvalid, t1_rdata,
    output t2_valid, t2_addr, t2_wdata, t2_we, t2_be,
    input  t2_ready, t2_rvalid, t2_rdata
  );

endinterface

// File: rtl/bus_demux3_decode.sv
// Address decoder: maps a request address to {hit, target index}, lowest index wins.
// Latency: combinational.
// No flow control.
module bus_addr_decode
  import bus_demux3_pkg::*;
#(
  parameter logic [31:0] BASE0 = DEFAULT_BASE0,
  parameter logic [31:0] MASK0 = DEFAULT_MASK0,
  parameter logic [31:0] BASE1 = DEFAULT_BASE1,
  parameter logic [31:0] MASK1 = DEFAULT_MASK1,
  parameter logic [31:0] BASE2 = DEFAULT_BASE2,
  parameter logic [31:0] MASK2 = DEFAULT_MASK2
) (
  input  logic [31:0] i_addr,
  output logic        o_hit,
  output logic [1:0]  o_idx
);

  logic [NUM_TARGETS-1:0] w_hit;

  assign w_hit[0] = addr_hit(i_addr, BASE0, MASK0);
  assign w_hit[1] = addr_hit(i_addr, BASE1, MASK1);
  assign w_hit[2] = addr_hit(i_addr, BASE2, MASK2);

  // Priority encode overlapping windows: target 0 beats 1 beats 2.
  always_comb begin
    o_hit = |w_hit;
    o_idx = 2'd0;
    if (w_hit[0])      o_idx = 2'd0;
    else if (w_hit[1]) o_idx = 2'd1;
    else if (w_hit[2]) o_idx = 2'd2;
  end

endmodule

// File: rtl/bus_demux3.sv
// Single-outstanding request demux from one initiator to three targets, with decode-miss and timeout errors.
// Latency: miss 1 cycle, zero-wait target 2 cycles, +1 per target wait cycle, capped at TIMEOUT+1.
// req_ready only in IDLE; the response strobe is never back-pressured.
module bus_demux3
  import bus_demux3_pkg::*;
#(
  parameter logic [31:0] BASE0   = DEFAULT_BASE0,
  parameter logic [31:0] MASK0   = DEFAULT_MASK0,
  parameter logic [31:0] BASE1   = DEFAULT_BASE1,
  parameter logic [31:0] MASK1   = DEFAULT_MASK1,
  parameter logic [31:0] BASE2   = DEFAULT_BASE2,
  parameter logic [31:0] MASK2   = DEFAULT_MASK2,
  parameter int          TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  bus_demux3_if.slave bus
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_be;
  logic        r_we, r_err;
  logic [1:0]  r_sel;
  logic [CW-1:0] r_cnt;

  logic        w_hit, w_accept, w_timeout, w_done;
  logic [1:0]  w_idx;
  logic        w_sel_ready, w_sel_rvalid;
  logic [31:0] w_sel_rdata;
  logic [NUM_TARGETS-1:0] w_t_ready, w_t_rvalid, w_t_drive;
  logic [31:0] w_t_rdata [NUM_TARGETS];

  bus_addr_decode #(
    .BASE0(BASE0), .MASK0(MASK0),
    .BASE1(BASE1), .MASK1(MASK1),
    .BASE2(BASE2), .MASK2(MASK2)
  ) u_decode (
    .i_addr (bus.req_addr),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  assign w_t_ready    = {bus.t2_ready, bus.t1_ready, bus.t0_ready};
  assign w_t_rvalid   = {bus.t2_rvalid, bus.t1_rvalid, bus.t0_rvalid};
  assign w_t_rdata[0] = bus.t0_rdata;
  assign w_t_rdata[1] = bus.t1_rdata;
  assign w_t_rdata[2] = bus.t2_rdata;

  // Only the latched target is ever listened to; other targets' strobes are ignored.
  assign w_sel_ready  = w_t_ready[r_sel];
  assign w_sel_rvalid = w_t_rvalid[r_sel];
  assign w_sel_rdata  = w_t_rdata[r_sel];

  assign w_accept  = bus.req_valid && (r_state == IDLE);
  // The cycle in which the counter would reach TIMEOUT ends the transaction, overriding completion.
  assign w_timeout = ((r_state == REQ) || (r_state == WAIT)) && (r_cnt == CNT_LAST);
  assign w_done    = !w_timeout && w_sel_rvalid &&
                     (((r_state == REQ) && w_sel_ready) || (r_state == WAIT));

  // State register; reset aborts any transaction without a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and target-select decode.
  always_comb begin
    w_state_nxt = r_state;
    w_t_drive   = '0;
    if (r_state == REQ) w_t_drive[r_sel] = 1'b1;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_hit ? REQ : RESP;
      REQ:     if (w_timeout || w_done) w_state_nxt = RESP;
               else if (w_sel_ready)   w_state_nxt = WAIT;
      WAIT:    if (w_timeout || w_done) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latch, timeout counter and registered response fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
      r_sel   <= 2'd0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= '0;
        if (w_hit) begin
          r_addr  <= bus.req_addr;
          r_wdata <= bus.req_wdata;
          r_be    <= bus.req_be;
          r_we    <= bus.req_we;
          r_sel   <= w_idx;
        end else begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
      end
      if (((r_state == REQ) || (r_state == WAIT)) && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + CW'(1);
      if (w_timeout) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end else if (w_done) begin
        r_rdata <= r_we ? 32'h0 : w_sel_rdata;
        r_err   <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

  assign bus.t0_valid = w_t_drive[0];
  assign bus.t0_addr  = w_t_drive[0] ? r_addr  : '0;
  assign bus.t0_wdata = w_t_drive[0] ? r_wdata : '0;
  assign bus.t0_be    = w_t_drive[0] ? r_be    : '0;
  assign bus.t0_we    = w_t_drive[0] & r_we;

  assign bus.t1_valid = w_t_drive[1];
  assign bus.t1_addr  = w_t_drive[1] ? r_addr  : '0;
  assign bus.t1_wdata = w_t_drive[1] ? r_wdata : '0;
  assign bus.t1_be    = w_t_drive[1] ? r_be    : '0;
  assign bus.t1_we    = w_t_drive[1] & r_we;

  assign bus.t2_valid = w_t_drive[2];
  assign bus.t2_addr  = w_t_drive[2] ? r_addr  : '0;
  assign bus.t2_wdata = w_t_drive[2] ? r_wdata : '0;
  assign bus.t2_be    = w_t_drive[2] ? r_be    : '0;
  assign bus.t2_we    = w_t_drive[2] & r_we;

endmodule

// File: tb/tb_bus_demux3.sv
// Bench for bus_demux3: directed corner transactions plus randomized traffic.
// Expected results come from a transaction-level model (address ranges, delay arithmetic).
// Targets are modelled per transaction; non-selected targets inject random noise.
module tb_bus_demux3;

  localparam int TIMEOUT = 16;
  localparam logic [31:0] EDGE_ADDR [6] = '{32'h0000_0FFF, 32'h0000_1000, 32'h1000_00FF,
                                             32'h1000_0100, 32'h1000_01FF, 32'h1000_0200};

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bus_demux3_if bif ();

  bus_demux3 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  logic [2:0]  tr, trv;
  logic [31:0] trd [3];
  assign bif.t0_ready = tr[0];  assign bif.t0_rvalid = trv[0];  assign bif.t0_rdata = trd[0];
  assign bif.t1_ready = tr[1];  assign bif.t1_rvalid = trv[1];  assign bif.t1_rdata = trd[1];
  assign bif.t2_ready = tr[2];  assign bif.t2_rvalid = trv[2];  assign bif.t2_rdata = trd[2];

  logic [2:0]  tv, twe;
  logic [31:0] ta [3];
  logic [31:0] tw [3];
  logic [3:0]  tbe [3];
  assign tv  = {bif.t2_valid, bif.t1_valid, bif.t0_valid};
  assign twe = {bif.t2_we, bif.t1_we, bif.t0_we};
  assign ta[0] = bif.t0_addr;   assign ta[1] = bif.t1_addr;   assign ta[2] = bif.t2_addr;
  assign tw[0] = bif.t0_wdata;  assign tw[1] = bif.t1_wdata;  assign tw[2] = bif.t2_wdata;
  assign tbe[0] = bif.t0_be;    assign tbe[1] = bif.t1_be;    assign tbe[2] = bif.t2_be;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Address map as plain ranges: RAM 4 KiB at 0, UART 256 B at 0x1000_0000, timer right after.
  function automatic int model_tgt(input logic [31:0] a);
    if (a < 32'h0000_1000) return 0;
    if (a >= 32'h1000_0000 && a < 32'h1000_0100) return 1;
    if (a >= 32'h1000_0100 && a < 32'h1000_0200) return 2;
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return $urandom & 32'h0000_0FFF;
      1:       return 32'h1000_0000 | ($urandom & 32'hFF);
      2:       return 32'h1000_0100 | ($urandom & 32'hFF);
      3:       return EDGE_ADDR[$urandom_range(0, 5)];
      default: return $urandom;
    endcase
  endfunction

  // Called and returns at a falling edge. The selected target raises ready in its
  // (rd_dly+1)-th request cycle and rvalid rv_dly cycles later. With hold set,
  // req_valid stays high and the task returns on the cycle the next request should be taken.
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int rd_dly, input int rv_dly, input logic [31:0] rdata,
                         input bit hold);
    int tgt, c, lat, vexp, win, lat_obs, rcnt, vcnt, other_v, fld_bad, zero_bad, rdy_bad;
    logic [31:0] exp_rd, rd_obs;
    logic exp_err, err_obs;
    tgt = model_tgt(addr);
    c = rd_dly + 1 + rv_dly;
    if (tgt < 0) begin
      lat = 1; exp_err = 1'b1; exp_rd = '0; vexp = 0;
    end else if (c >= TIMEOUT) begin
      lat = TIMEOUT + 1; exp_err = 1'b1; exp_rd = '0;
      vexp = (rd_dly + 1 < TIMEOUT) ? rd_dly + 1 : TIMEOUT;
    end else begin
      lat = c + 1; exp_err = 1'b0; exp_rd = we ? 32'h0 : rdata; vexp = rd_dly + 1;
    end
    win = hold ? lat + 1 : TIMEOUT + 3;
    bif.req_valid = 1'b1; bif.req_addr = addr; bif.req_we = we;
    bif.req_wdata = wdata; bif.req_be = be;
    tr = '0; trv = '0;
    chk({tag, ":ready_at_start"}, bif.req_ready, 1);
    lat_obs = 0; rcnt = 0; vcnt = 0; other_v = 0; fld_bad = 0; zero_bad = 0; rdy_bad = 0;
    rd_obs = '0; err_obs = 1'b0;
    for (int n = 1; n <= win; n++) begin
      @(negedge clk);
      if (!hold) bif.req_valid = 1'b0;
      if (bif.req_ready !== (n > lat)) rdy_bad++;
      if (bif.resp_valid === 1'b1) begin
        rcnt++;
        if (lat_obs == 0) begin
          lat_obs = n; rd_obs = bif.resp_rdata; err_obs = bif.resp_err;
        end
      end
      for (int t = 0; t < 3; t++) begin
        if (t == tgt) begin
          if (tv[t] === 1'b1) begin
            vcnt++;
            if (ta[t] !== addr || tw[t] !== wdata || tbe[t] !== be || twe[t] !== we) fld_bad++;
          end
          tr[t]  = (n == rd_dly + 1);
          trv[t] = (n == c);
          trd[t] = (n == c) ? rdata : $urandom;
        end else begin
          if (tv[t] !== 1'b0) other_v++;
          if (ta[t] !== 0 || tw[t] !== 0 || tbe[t] !== 0 || twe[t] !== 1'b0) zero_bad++;
          tr[t]  = 1'($urandom_range(0, 1));
          trv[t] = 1'($urandom_range(0, 1));
          trd[t] = $urandom;
        end
      end
    end
    if (!hold) begin tr = '0; trv = '0; end
    chk({tag, ":latency"}, lat_obs, lat);
    chk({tag, ":rdata"}, rd_obs, exp_rd);
    chk({tag, ":err"}, err_obs, exp_err);
    chk({tag, ":resp_count"}, rcnt, 1);
    chk({tag, ":sel_valid_cycles"}, vcnt, vexp);
    chk({tag, ":sel_fields_bad"}, fld_bad, 0);
    chk({tag, ":other_valid"}, other_v, 0);
    chk({tag, ":other_fields_nonzero"}, zero_bad, 0);
    chk({tag, ":ready_pattern_bad"}, rdy_bad, 0);
  endtask

  initial begin
    int rc;
    bif.req_valid = 1'b0; bif.req_addr = '0; bif.req_we = 1'b0;
    bif.req_wdata = '0; bif.req_be = '0;
    tr = '0; trv = '0;
    for (int t = 0; t < 3; t++) trd[t] = '0;

    // Reset state, observed before any clock edge.
    #1 reset = 1'b1;
    #2;
    chk("rst:resp_valid", bif.resp_valid, 0);
    chk("rst:resp_err", bif.resp_err, 0);
    chk("rst:resp_rdata", bif.resp_rdata, 0);
    chk("rst:t_valid", tv, 0);
    chk("rst:t0_addr", ta[0], 0);
    chk("rst:req_ready", bif.req_ready, 1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed corner transactions.
    run_txn("rd_t0_zero_wait", 32'h0000_0010, 1'b0, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0);
    run_txn("wr_t1_waits", 32'h1000_0004, 1'b1, 32'h0000_0041, 4'b0001, 2, 3, 32'h1234_5678, 1'b0);
    run_txn("miss", 32'h2000_0000, 1'b0, 32'h0, 4'hF, 0, 0, 32'h5555_5555, 1'b0);
    run_txn("t2_timeout", 32'h1000_0100, 1'b0, 32'h0, 4'hF, 100, 0, 32'h6666_6666, 1'b0);
    run_txn("just_in_time", 32'h0000_0FFC, 1'b0, 32'h0, 4'hF, 0, 14, 32'h0BAD_F00D, 1'b0);
    run_txn("tie_timeout", 32'h1000_01F0, 1'b0, 32'h0, 4'hF, 3, 12, 32'h7777_7777, 1'b0);
    run_txn("b2b_first", 32'h0000_0100, 1'b0, 32'h0, 4'hF, 0, 0, 32'hCAFE_0001, 1'b1);
    run_txn("b2b_second", 32'h1000_0080, 1'b0, 32'h0, 4'h3, 1, 0, 32'hCAFE_0002, 1'b0);

    // Reset while the target is being offered a request: valid must drop without a clock edge.
    bif.req_valid = 1'b1; bif.req_addr = 32'h0000_0020; bif.req_we = 1'b0;
    @(negedge clk);
    bif.req_valid = 1'b0;
    chk("rstA:t0_valid_before", tv[0], 1);
    #2 reset = 1'b1;
    #1;
    chk("rstA:t0_valid_async", tv[0], 0);
    chk("rstA:resp_valid", bif.resp_valid, 0);
    @(negedge clk);
    reset = 1'b0;

    run_txn("pre_rst_read", 32'h0000_0040, 1'b0, 32'h0, 4'hF, 0, 0, 32'hA5A5_0001, 1'b0);

    // Reset while waiting for read data from target 0.
    bif.req_valid = 1'b1; bif.req_addr = 32'h0000_0030; bif.req_we = 1'b0;
    @(negedge clk);
    bif.req_valid = 1'b0;
    tr[0] = 1'b1;
    @(negedge clk);
    tr[0] = 1'b0;
    chk("rstB:t0_valid_in_wait", tv[0], 0);
    #2 reset = 1'b1;
    trv[0] = 1'b1; trd[0] = 32'hFFFF_FFFF;
    #1;
    chk("rstB:resp_rdata", bif.resp_rdata, 0);
    chk("rstB:resp_err", bif.resp_err, 0);
    chk("rstB:resp_valid", bif.resp_valid, 0);
    chk("rstB:req_ready", bif.req_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    trv[0] = 1'b0;
    rc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bif.resp_valid === 1'b1) rc++;
    end
    chk("rstB:no_response", rc, 0);
    run_txn("post_rst", 32'h0000_0ABC, 1'b0, 32'h0, 4'hF, 1, 1, 32'h1357_9BDF, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int rd, rv;
      rd = $urandom_range(0, 3);
      rv = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) begin
        rd = $urandom_range(10, 16);
        rv = $urandom_range(0, 6);
      end
      run_txn($sformatf("rnd%0d", i), rand_addr(), 1'($urandom_range(0, 1)), $urandom,
              4'($urandom), rd, rv, $urandom, (i < 39) && ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_demux3.md
BUS_DEMUX3 -- requirements
Module: bus_demux3

Interface
REQ-001 Parameter BASE0, default 32'h0000_0000, target 0 (data RAM) base address.
REQ-002 Parameter MASK0, default 32'hFFFF_F000, target 0 decode mask.
REQ-003 Parameter BASE1/MASK1, defaults 32'h1000_0000/32'hFFFF_FF00, target 1 (UART).
REQ-004 Parameter BASE2/MASK2, defaults 32'h1000_0100/32'hFFFF_FF00, target 2 (timer).
REQ-005 Parameter TIMEOUT, default 16, maximum cycles spent in REQ+WAIT before an error response.
REQ-006 Ports, in order:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid/req_ready  in/out  1  initiator request handshake.
- req_addr  in  32.
- req_we  in  1.
- req_wdata  in  32.
- req_be  in  4.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32.
- resp_err  out  1  decode miss or timeout.
- tN_valid/tN_ready  out/in  1  per target N=0..2.
- tN_addr/tN_wdata  out  32.
- tN_we  out  1.
- tN_be  out  4.
- tN_rvalid  in  1  per target; completion for both reads and writes.
- tN_rdata  in  32.

Function
REQ-007 FSM states: IDLE, REQ, WAIT, RESP; exactly one request is outstanding at any time.
REQ-008 req_ready = 1 only in IDLE; a request is accepted on a clock edge where req_valid && req_ready.
REQ-009 Decode: hitN = ((req_addr & MASKN) == BASEN); on overlapping hits, priority is 0 > 1 > 2.
REQ-010 IDLE, accepted with a hit: latch addr/we/wdata/be and the target index, then go to REQ.
REQ-011 IDLE, accepted with no hit: go to RESP with resp_err=1 and resp_rdata=0; resp_valid asserts 1 cycle after acceptance.
REQ-012 REQ: the selected tN_valid=1, driven with the latched fields; all other tN_valid=0. On tN_ready: if tN_rvalid is also 1, go to RESP; otherwise go to WAIT.
REQ-013 WAIT: tN_valid=0; on tN_rvalid, capture tN_rdata and go to RESP. rvalid from non-selected targets is ignored in every state.
REQ-014 RESP: resp_valid=1 for exactly one cycle, with registered resp_rdata/resp_err; always return to IDLE on the next cycle. The initiator is not back-pressured.
REQ-015 For writes, resp_rdata = 0 regardless of tN_rdata.
REQ-016 Latency: a zero-wait target gives resp_valid 2 cycles after acceptance; each target wait cycle adds 1.
REQ-017 Timeout counter: cleared on acceptance, increments each cycle in REQ or WAIT. When it reaches TIMEOUT, go to RESP with resp_err=1 and resp_rdata=0, and drop tN_valid. Timeout takes priority over a ready/rvalid arriving in the same cycle.
REQ-018 The counter width is $clog2(TIMEOUT+1) and it does not wrap.
REQ-019 Non-selected target outputs: valid=0; addr/wdata/be/we = 0.

Reset
REQ-020 Reset is asynchronous and active-high. While asserted: state=IDLE, counter=0, latched fields=0, resp_valid=0, resp_rdata=0, resp_err=0, all tN_valid=0.
REQ-021 Reset asserted mid-transaction aborts the transaction with no response; the target sees tN_valid fall immediately.
REQ-022 req_ready=1 on the first cycle after reset deasserts.

Structure
REQ-023 Package bus_demux3_pkg holds: the state enum (IDLE/REQ/WAIT/RESP), NUM_TARGETS=3, the default BASE/MASK constants, and DEFAULT_TIMEOUT=16.
REQ-024 One sub-module, bus_addr_decode: combinational address -> {hit, index[1:0]}, implementing the REQ-009 priority.

Verification
REQ-025 Read 0x0000_0010; t0 ready+rvalid same cycle with rdata 0xDEAD_BEEF -> resp_valid 2 cycles after acceptance, rdata 0xDEAD_BEEF, err=0.
REQ-026 Write 0x1000_0004, wdata 0x41, be 4'b0001; t1 ready after 2 cycles, rvalid 3 cycles later -> t1 sees exact fields, resp rdata=0, err=0, t0/t2 valid stay 0.
REQ-027 Read 0x2000_0000 (no hit) -> resp_valid 1 cycle after acceptance with err=1, rdata=0, and no tN_valid ever asserted.
REQ-028 Read 0x1000_0100; t2 never asserts ready -> t2_valid drops and resp_err=1 exactly TIMEOUT=16 cycles after acceptance + 1.
REQ-029 Reset pulsed while in WAIT for t0 -> outputs reach reset values asynchronously, no resp_valid, and a following request completes normally.
REQ-030 Back-to-back requests with req_valid held high -> req_ready low from acceptance until the cycle after resp_valid, and the second request is accepted then.
